// File: rtl/pc_fetch.sv
// Program-counter fetch stage: IDLE/FETCH/HALTED control with a registered PC and sequential/branch next-PC select.
// Optional feature: define PC_FETCH_BRBUF_EN to keep a one-entry buffer for branches that arrive during a stall.
module pc_fetch #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0,
    parameter logic [WIDTH-1:0] INC        = WIDTH'(4)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] BT,
    input  logic             BR,
    input  logic             HALT,
    input  logic             RDY,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC4,
    output logic             VALID
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_p0, state_nx;
    logic [WIDTH-1:0] pc_p0, pc_nx;
    logic             accept;

    // Sequential successor; the adder width makes the top-to-bottom wrap implicit.
    function automatic logic [WIDTH-1:0] next_seq(input logic [WIDTH-1:0] addr);
        return addr + INC;
    endfunction

`ifdef PC_FETCH_BRBUF_EN
    logic             pend_vld_p0, pend_vld_nx;
    logic [WIDTH-1:0] pend_p0, pend_nx;
`endif

    assign VALID  = (state_p0 == FETCH);
    assign accept = VALID && RDY;
    assign PC     = pc_p0;
    assign PC4    = next_seq(pc_p0);

    always_comb begin
        state_nx = state_p0;
        pc_nx    = pc_p0;
`ifdef PC_FETCH_BRBUF_EN
        pend_vld_nx = pend_vld_p0;
        pend_nx     = pend_p0;
`endif
        case (state_p0)
            IDLE: state_nx = FETCH;
            FETCH: begin
                if (accept) begin
`ifdef PC_FETCH_BRBUF_EN
                    // A live branch beats an older buffered one.
                    if (BR)
                        pc_nx = BT;
                    else if (pend_vld_p0)
                        pc_nx = pend_p0;
                    else
                        pc_nx = PC4;
                    pend_vld_nx = 1'b0;
`else
                    pc_nx = BR ? BT : PC4;
`endif
                end
`ifdef PC_FETCH_BRBUF_EN
                else if (BR) begin
                    pend_vld_nx = 1'b1;
                    pend_nx     = BT;
                end
`endif
                if (HALT)
                    state_nx = HALTED;
            end
            HALTED: begin
                if (BR)
                    pc_nx = BT;
                if (!HALT)
                    state_nx = FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p0: control state and PC register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_p0 <= IDLE;
            pc_p0    <= RESET_ADDR;
`ifdef PC_FETCH_BRBUF_EN
            pend_vld_p0 <= 1'b0;
`endif
        end else begin
            state_p0 <= state_nx;
            pc_p0    <= pc_nx;
`ifdef PC_FETCH_BRBUF_EN
            pend_vld_p0 <= pend_vld_nx;
`endif
        end
    end

`ifdef PC_FETCH_BRBUF_EN
    always_ff @(posedge CLK) begin
        pend_p0 <= pend_nx;
    end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: a 32-bit instance driven by directed vectors and an 8-bit instance free-running to exercise wrap.
module tb_pc_fetch;

    localparam bit BUFEN =
`ifdef PC_FETCH_BRBUF_EN
        1'b1;
`else
        1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic [31:0] BT;
    logic        BR, HALT, RDY;
    logic [31:0] PC, PC4;
    logic        VALID;

    logic [7:0]  bt8;
    logic        br8, halt8, rdy8;
    logic [7:0]  pc8, pc48;
    logic        valid8;

    int errs   = 0;
    int checks = 0;
    bit armed  = 0;

    pc_fetch #(.WIDTH(32), .RESET_ADDR(32'h100), .INC(32'd4)) dut (
        .CLK(CLK), .RST(RST), .BT(BT), .BR(BR), .HALT(HALT), .RDY(RDY),
        .PC(PC), .PC4(PC4), .VALID(VALID)
    );

    pc_fetch #(.WIDTH(8), .RESET_ADDR(8'hF8), .INC(8'd4)) dut8 (
        .CLK(CLK), .RST(RST), .BT(bt8), .BR(br8), .HALT(halt8), .RDY(rdy8),
        .PC(pc8), .PC4(pc48), .VALID(valid8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model: fetching starts one cycle after reset, halted suppresses VALID.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pt;
        bit          started;
        bit          halted;
        bit          pend;
    } mst_t;

    mst_t m32, m8;

    function automatic mst_t mreset(input logic [31:0] addr);
        mst_t r;
        r.pc = addr; r.pt = '0; r.started = 1'b0; r.halted = 1'b0; r.pend = 1'b0;
        return r;
    endfunction

    function automatic mst_t mstep(input mst_t s, input logic br, input logic halt, input logic rdy,
                                   input logic [31:0] bt, input logic [31:0] mask);
        mst_t n = s;
        if (!s.started) begin
            n.started = 1'b1;
        end else if (s.halted) begin
            if (br) n.pc = bt & mask;
            if (!halt) n.halted = 1'b0;
        end else begin
            if (rdy) begin
                n.pc   = br ? (bt & mask) : (s.pend ? s.pt : ((s.pc + 32'd4) & mask));
                n.pend = 1'b0;
            end else if (br && BUFEN) begin
                n.pend = 1'b1;
                n.pt   = bt & mask;
            end
            if (halt) n.halted = 1'b1;
        end
        return n;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m32 <= mreset(32'h100);
            m8  <= mreset(32'hF8);
        end else begin
            m32 <= mstep(m32, BR, HALT, RDY, BT, 32'hFFFF_FFFF);
            m8  <= mstep(m8, br8, halt8, rdy8, {24'h0, bt8}, 32'h0000_00FF);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (armed) begin
            chk("m32.PC", PC, m32.pc);
            chk("m32.PC4", PC4, m32.pc + 32'd4);
            chk("m32.VALID", {31'h0, VALID}, {31'h0, m32.started && !m32.halted});
            chk("m8.PC", {24'h0, pc8}, m8.pc);
            chk("m8.PC4", {24'h0, pc48}, (m8.pc + 32'd4) & 32'hFF);
            chk("m8.VALID", {31'h0, valid8}, {31'h0, m8.started && !m8.halted});
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        RST = 1'b1; RDY = 1'b1; BR = 1'b0; HALT = 1'b0; BT = '0;
        bt8 = '0; br8 = 1'b0; halt8 = 1'b0; rdy8 = 1'b1;
        tick(); tick();
        armed = 1'b1;
        chk("rst.PC", PC, 32'h100);
        chk("rst.PC4", PC4, 32'h104);
        chk("rst.VALID", {31'h0, VALID}, 32'h0);

        RST = 1'b0;
        #1 chk("idle.VALID", {31'h0, VALID}, 32'h0);
        tick();
        chk("seq0.PC", PC, 32'h100);
        chk("seq0.VALID", {31'h0, VALID}, 32'h1);
        chk("w8.0", {24'h0, pc8}, 32'hF8);
        tick();
        chk("seq1.PC", PC, 32'h104);
        chk("w8.1", {24'h0, pc8}, 32'hFC);
        tick();
        chk("seq2.PC", PC, 32'h108);
        chk("wrap.PC", {24'h0, pc8}, 32'h00);
        chk("wrap.PC4", {24'h0, pc48}, 32'h04);

        BR = 1'b1; BT = 32'h200;
        tick();
        chk("br.PC", PC, 32'h200);
        chk("br.PC4", PC4, 32'h204);
        BR = 1'b0;
        tick(); tick(); tick();
        chk("pre_stall.PC", PC, 32'h20C);

        RDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.PC", PC, 32'h20C);
            chk("stall.VALID", {31'h0, VALID}, 32'h1);
        end
        RDY = 1'b1;
        tick();
        chk("unstall.PC", PC, 32'h210);

        RDY = 1'b0; BR = 1'b1; BT = 32'h40;
        tick();
        BR = 1'b0;
        tick();
        chk("pend_hold.PC", PC, 32'h210);
        RDY = 1'b1;
        tick();
        chk("pend.PC", PC, BUFEN ? 32'h40 : 32'h214);

        RDY = 1'b0; BR = 1'b1; BT = 32'h60;
        tick();
        BT = 32'h70; RDY = 1'b1;
        tick();
        chk("override.PC", PC, 32'h70);
        BR = 1'b0;

        HALT = 1'b1;
        tick();
        chk("halt.PC", PC, 32'h74);
        chk("halt.VALID", {31'h0, VALID}, 32'h0);
        tick();
        chk("halt_frozen.PC", PC, 32'h74);
        BR = 1'b1; BT = 32'h80;
        tick();
        chk("redirect.PC", PC, 32'h80);
        chk("redirect.VALID", {31'h0, VALID}, 32'h0);
        BR = 1'b0;
        tick();
        HALT = 1'b0;
        tick();
        chk("resume.PC", PC, 32'h80);
        chk("resume.VALID", {31'h0, VALID}, 32'h1);
        tick();
        chk("resume1.PC", PC, 32'h84);

        BR = 1'b1; BT = 32'h300; HALT = 1'b1;
        tick();
        chk("brhalt.PC", PC, 32'h300);
        chk("brhalt.VALID", {31'h0, VALID}, 32'h0);
        BR = 1'b0; HALT = 1'b0;
        tick();
        chk("brhalt_resume.PC", PC, 32'h300);
        tick();
        chk("brhalt_seq.PC", PC, 32'h304);

        RDY = 1'b0;
        tick(); tick();
        chk("prereset.PC", PC, 32'h304);
        #1 RST = 1'b1;
        #1 chk("async.PC", PC, 32'h100);
        chk("async.VALID", {31'h0, VALID}, 32'h0);
        chk("async8.PC", {24'h0, pc8}, 32'hF8);
        tick();
        RST = 1'b0;
        tick();
        chk("post_rst.PC", PC, 32'h100);
        chk("post_rst.VALID", {31'h0, VALID}, 32'h1);
        RDY = 1'b1;
        tick();
        chk("post_rst1.PC", PC, 32'h104);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: address width in bits.
REQ-002 SHALL provide parameter RESET_ADDR, default 0: PC value loaded on reset.
REQ-003 SHALL provide parameter INC, default 4: sequential PC increment.
REQ-004 SHALL have port CLK  input  1  sole clock, rising-edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port BT  input  WIDTH  branch target; drives the D1 leg of the downstream 2:1 next-PC mux.
REQ-007 SHALL have port BR  input  1  branch taken; drives the S leg of the downstream mux.
REQ-008 SHALL have port HALT  input  1  stop fetching.
REQ-009 SHALL have port RDY  input  1  instruction memory ready to accept the address.
REQ-010 SHALL have port PC  output  WIDTH  current fetch address.
REQ-011 SHALL have port PC4  output  WIDTH  PC+INC; drives the D0 leg of the downstream mux.
REQ-012 SHALL have port VALID  output  1  PC is a live fetch request.

Function
REQ-013 SHALL implement the states IDLE, FETCH and HALTED.
REQ-014 SHALL go from IDLE to FETCH one cycle after reset release; VALID=0 in IDLE.
REQ-015 SHALL hold VALID=1 in FETCH and VALID=0 in IDLE and HALTED.
REQ-016 SHALL define accept as VALID&&RDY; PC SHALL change only in an accept cycle or a redirect cycle (REQ-019).
REQ-017 SHALL, on accept, load PC with BT when BR=1 and with PC4 when BR=0 (Y=S?D1:D0 semantics).
REQ-018 SHALL compute PC4 combinationally as (PC+INC) modulo 2^WIDTH; PC wraps from the top address to the low address with no flag.
REQ-019 SHALL, in HALTED with BR=1, load PC with BT (redirect) while keeping VALID=0.
REQ-020 SHALL move from FETCH to HALTED on HALT=1 after completing that cycle's accept if one occurs; HALT wins over VALID in the following cycle.
REQ-021 SHALL move from HALTED to FETCH on the first cycle with HALT=0.
REQ-022 SHALL hold PC and VALID stable while VALID=1 and RDY=0; PC SHALL not depend on RDY combinationally.
REQ-023 SHALL, when BR=1 and HALT=1 arrive in the same accept cycle, take the branch first and then halt, with PC=BT.

Reset
REQ-024 SHALL, on RST=1 at any time including mid-stall, immediately set PC=RESET_ADDR, VALID=0, state=IDLE and clear the pending-branch register.
REQ-025 SHALL keep all outputs at their reset values while RST=1; PC4=RESET_ADDR+INC.

Configuration
REQ-026 SHALL, with PC_FETCH_BRBUF_EN defined, capture BT into a one-entry pending register when BR=1 and VALID=1 and RDY=0 (the newest branch overwrites an older one).
REQ-027 SHALL, with PC_FETCH_BRBUF_EN defined, on the next accept load PC with the pending target, even if BR=0, and then clear the pending register; an accept-cycle BR=1 overrides the pending target.
REQ-028 SHALL, without PC_FETCH_BRBUF_EN, honour BR only in accept or HALTED cycles and ignore it during a stall, with no pending register synthesized.

Verification
REQ-029 SHALL cover reset: WIDTH=32, RESET_ADDR=0x100, RST pulse, RDY=1 -> VALID=0 for 1 cycle, then PC sequence 0x100, 0x104, 0x108.
REQ-030 SHALL cover branch: PC=0x108, BR=1, BT=0x200, RDY=1 -> PC=0x200 next cycle and PC4=0x204.
REQ-031 SHALL cover stall: RDY=0 for 3 cycles at PC=0x20C -> PC=0x20C and VALID=1 held throughout; PC=0x210 one cycle after RDY=1.
REQ-032 SHALL cover wrap: WIDTH=8, PC=0xFC, accept -> PC=0x00, PC4=0x04.
REQ-033 SHALL cover pending branch with PC_FETCH_BRBUF_EN: BR=1 and BT=0x40 during RDY=0, then BR=0 and RDY=1 -> PC=0x40; without the macro -> PC=old PC+4.
REQ-034 SHALL cover halt and async reset: HALT=1 -> VALID=0 with PC frozen; BR=1 and BT=0x80 while halted -> PC=0x80; RST raised mid-cycle -> PC=RESET_ADDR before the next CLK edge.
